sd_sck_generator: RTL and testbench

// - Parametrised SD/SPI serial-clock generator that replaces fixed free-running clock dividers.
// - Derives SCK from the single system clock using a runtime-selectable half-period: slow init, fast transfer, or custom.
// - Provides one-cycle rise/fall strobes so the SD controller runs on the system clock, not on a derived clock.
// - Counted-burst mode produces exact SCK cycle counts, e.g. the 74-clock SD power-up sequence.

---
 rtl/sd_sck_generator_if.sv | 30 +++
 rtl/sd_sck_generator.sv | 144 ++++++++++++++
 tb/tb_sd_sck_generator.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/sd_sck_generator_if.sv
// Bundle of request, configuration and status signals between an SD/SPI
// controller and the serial-clock generator.
//   master : controller side; drives enable, burst_start, burst_len, div_sel, div_custom.
//   slave  : generator side; drives sck, sck_rise, sck_fall, running, burst_done, div_active.
interface sd_sck_generator_if #(
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned BURST_WIDTH = 8
);
  logic                   enable;
  logic                   burst_start;
  logic [BURST_WIDTH-1:0] burst_len;
  logic [1:0]             div_sel;
  logic [CNT_WIDTH-1:0]   div_custom;
  logic                   sck;
  logic                   sck_rise;
  logic                   sck_fall;
  logic                   running;
  logic                   burst_done;
  logic [CNT_WIDTH-1:0]   div_active;

  modport master (
    output enable, burst_start, burst_len, div_sel, div_custom,
    input  sck, sck_rise, sck_fall, running, burst_done, div_active
  );

  modport slave (
    input  enable, burst_start, burst_len, div_sel, div_custom,
    output sck, sck_rise, sck_fall, running, burst_done, div_active
  );
endinterface

// File: rtl/sd_sck_generator.sv
// SD/SPI serial-clock generator. Produces a registered CPOL=0 SCK from the
// system clock with a runtime-selectable half-period, plus one-cycle rise/fall
// strobes so the controller can stay on the system clock. Supports a
// free-running mode (enable level) and a counted burst (burst_start pulse).
// Ports:
//   clock   : system clock, posedge
//   n_reset : asynchronous active-low reset
//   bus     : sd_sck_generator_if slave modport (requests in, SCK/status out)
module sd_sck_generator #(
  parameter int unsigned CNT_WIDTH   = 8,
  parameter int unsigned SLOW_DIV    = 125,
  parameter int unsigned FAST_DIV    = 4,
  parameter int unsigned BURST_WIDTH = 8
) (
  input logic                clock,
  input logic                n_reset,
  sd_sck_generator_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  localparam logic [CNT_WIDTH-1:0]   CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [BURST_WIDTH-1:0] BURST_ONE = BURST_WIDTH'(1);

  logic [1:0]             state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [BURST_WIDTH-1:0] remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0]   div_active_q, div_active_d;
  logic                   sck_q, sck_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   done_q, done_d;
  logic [CNT_WIDTH-1:0]   div_target;
  logic                   last_cnt;

  always_comb begin
    div_target = CNT_WIDTH'(SLOW_DIV);
    unique case (bus.div_sel)
      2'd0:    div_target = CNT_WIDTH'(SLOW_DIV);
      2'd1:    div_target = CNT_WIDTH'(FAST_DIV);
      default: div_target = (bus.div_custom == '0) ? CNT_ONE : bus.div_custom;
    endcase
  end

  assign last_cnt = (cnt_q == (div_active_q - CNT_ONE));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    remaining_d  = remaining_q;
    div_active_d = div_active_q;
    sck_d        = sck_q;
    rise_d       = 1'b0;
    fall_d       = 1'b0;
    done_d       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        sck_d        = 1'b0;
        cnt_d        = '0;
        div_active_d = div_target;
        if (bus.burst_start) begin
          if (bus.burst_len != '0) begin
            state_d     = ST_BURST;
            remaining_d = bus.burst_len;
          end else begin
            // Zero-length burst completes immediately without any SCK edge.
            done_d = 1'b1;
          end
        end else if (bus.enable) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN, ST_BURST: begin
        if ((state_q == ST_RUN) && !bus.enable && !sck_q) begin
          // Low phase can be abandoned at once: no pulse gets truncated.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (last_cnt) begin
          cnt_d = '0;
          sck_d = ~sck_q;
          if (sck_q) begin
            fall_d = 1'b1;
            // Divisor only changes at a fall so a high phase is never reshaped.
            div_active_d = div_target;
            if ((state_q == ST_RUN) && !bus.enable) begin
              state_d = ST_IDLE;
            end
            if (state_q == ST_BURST) begin
              remaining_d = remaining_q - BURST_ONE;
              if (remaining_q == BURST_ONE) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end
            end
          end else begin
            rise_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        sck_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      remaining_q  <= '0;
      div_active_q <= CNT_WIDTH'(SLOW_DIV);
      sck_q        <= 1'b0;
      rise_q       <= 1'b0;
      fall_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      remaining_q  <= remaining_d;
      div_active_q <= div_active_d;
      sck_q        <= sck_d;
      rise_q       <= rise_d;
      fall_q       <= fall_d;
      done_q       <= done_d;
    end
  end

  assign bus.sck        = sck_q;
  assign bus.sck_rise   = rise_q;
  assign bus.sck_fall   = fall_q;
  assign bus.burst_done = done_q;
  assign bus.div_active = div_active_q;
  assign bus.running    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sd_sck_generator.sv
module tb_sd_sck_generator;

  logic clock = 1'b0;
  logic n_reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  sd_sck_generator_if #(.CNT_WIDTH(8), .BURST_WIDTH(8)) bus ();

  sd_sck_generator #(
    .CNT_WIDTH  (8),
    .SLOW_DIV   (125),
    .FAST_DIV   (4),
    .BURST_WIDTH(8)
  ) dut (
    .clock  (clock),
    .n_reset(n_reset),
    .bus    (bus.slave)
  );

  // Advances one clock and returns at the following negedge (sampling point).
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Counts posedges until the requested strobe is seen; -1 on timeout.
  task automatic wait_edge(input bit want_rise, input int bound, output int n);
    n = 0;
    forever begin
      step();
      n++;
      if (want_rise ? bus.sck_rise : bus.sck_fall) return;
      if (n >= bound) begin
        n = -1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    bus.enable = 0; bus.burst_start = 0; bus.burst_len = 0;
    bus.div_sel = 0; bus.div_custom = 0;
    n_reset = 0;
    step(); step();
    checks++; if (bus.sck !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b exp=0", bus.sck); end
    checks++; if (bus.running !== 1'b0) begin failures++; $display("FAIL reset_running got=%b exp=0", bus.running); end
    checks++; if (bus.div_active !== 8'd125) begin failures++; $display("FAIL reset_div got=%0d exp=125", bus.div_active); end
    checks++; if ({bus.sck_rise, bus.sck_fall, bus.burst_done} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {bus.sck_rise, bus.sck_fall, bus.burst_done}); end
    n_reset = 1;
    step();
    checks++; if (bus.running !== 1'b0) begin failures++; $display("FAIL idle_after_reset got=%b exp=0", bus.running); end
    n = 0;
  endtask

  task automatic test_slow_run();
    int n;
    bus.div_sel = 0; bus.enable = 1;
    // First posedge samples enable; rise is 125 clocks after that.
    wait_edge(1, 400, n);
    checks++; if (n !== 126) begin failures++; $display("FAIL slow_first_rise got=%0d exp=126", n); end
    checks++; if (bus.running !== 1'b1) begin failures++; $display("FAIL slow_running got=%b exp=1", bus.running); end
    wait_edge(0, 400, n);
    checks++; if (n !== 125) begin failures++; $display("FAIL slow_high got=%0d exp=125", n); end
    wait_edge(1, 400, n);
    checks++; if (n !== 125) begin failures++; $display("FAIL slow_low got=%0d exp=125", n); end
    wait_edge(0, 400, n);
    checks++; if (n !== 125) begin failures++; $display("FAIL slow_high2 got=%0d exp=125", n); end
  endtask

  task automatic test_div_switch();
    int n;
    wait_edge(1, 400, n);
    checks++; if (n !== 125) begin failures++; $display("FAIL sw_rise got=%0d exp=125", n); end
    for (int i = 0; i < 10; i++) step();
    bus.div_sel = 1;
    wait_edge(0, 400, n);
    checks++; if (n !== 115) begin failures++; $display("FAIL sw_high_rest got=%0d exp=115", n); end
    checks++; if (bus.div_active !== 8'd4) begin failures++; $display("FAIL sw_div_active got=%0d exp=4", bus.div_active); end
    wait_edge(1, 400, n);
    checks++; if (n !== 4) begin failures++; $display("FAIL sw_low got=%0d exp=4", n); end
    wait_edge(0, 400, n);
    checks++; if (n !== 4) begin failures++; $display("FAIL sw_high_fast got=%0d exp=4", n); end
    wait_edge(1, 400, n);
    checks++; if (n !== 4) begin failures++; $display("FAIL sw_low_fast got=%0d exp=4", n); end
  endtask

  task automatic test_enable_drop();
    int n;
    int rises;
    bus.div_sel = 0;
    // High phase already in progress keeps the fast divisor.
    wait_edge(0, 400, n);
    checks++; if (n !== 4) begin failures++; $display("FAIL drop_fast_high got=%0d exp=4", n); end
    wait_edge(1, 400, n);
    checks++; if (n !== 125) begin failures++; $display("FAIL drop_slow_low got=%0d exp=125", n); end
    for (int i = 0; i < 10; i++) step();
    bus.enable = 0;
    wait_edge(0, 400, n);
    checks++; if (n !== 115) begin failures++; $display("FAIL drop_fall got=%0d exp=115", n); end
    checks++; if (bus.running !== 1'b0) begin failures++; $display("FAIL drop_running got=%b exp=0", bus.running); end
    rises = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.sck_rise || bus.sck) rises++;
    end
    checks++; if (rises !== 0) begin failures++; $display("FAIL drop_no_rise got=%0d exp=0", rises); end
    bus.enable = 1;
    wait_edge(1, 400, n);
    checks++; if (n !== 126) begin failures++; $display("FAIL reraise_rise got=%0d exp=126", n); end
    // Now drop while sck is low: exit on the next edge with no strobe.
    wait_edge(0, 400, n);
    for (int i = 0; i < 3; i++) step();
    bus.enable = 0;
    step();
    checks++; if (bus.running !== 1'b0) begin failures++; $display("FAIL lowdrop_running got=%b exp=0", bus.running); end
    checks++; if ({bus.sck, bus.sck_rise, bus.sck_fall} !== 3'b000) begin failures++; $display("FAIL lowdrop_sck got=%b exp=000", {bus.sck, bus.sck_rise, bus.sck_fall}); end
  endtask

  task automatic test_burst74();
    int r;
    int f;
    int n;
    bit done_seen;
    bus.div_sel = 0; bus.burst_len = 8'd74; bus.burst_start = 1;
    step();
    bus.burst_start = 0;
    r = 0; f = 0; n = 0; done_seen = 0;
    while (!done_seen && n < 20000) begin
      if (bus.sck_rise) r++;
      if (bus.sck_fall) f++;
      if (bus.burst_done) begin
        done_seen = 1;
        checks++; if (bus.sck_fall !== 1'b1) begin failures++; $display("FAIL burst_done_with_fall got=%b exp=1", bus.sck_fall); end
        checks++; if (bus.running !== 1'b0) begin failures++; $display("FAIL burst_running_end got=%b exp=0", bus.running); end
      end else begin
        step();
        n++;
      end
    end
    checks++; if (done_seen !== 1'b1) begin failures++; $display("FAIL burst_done_seen got=%b exp=1", done_seen); end
    checks++; if (r !== 74) begin failures++; $display("FAIL burst_rises got=%0d exp=74", r); end
    checks++; if (f !== 74) begin failures++; $display("FAIL burst_falls got=%0d exp=74", f); end
    r = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.sck || bus.running || bus.burst_done) r++;
    end
    checks++; if (r !== 0) begin failures++; $display("FAIL burst_idle_after got=%0d exp=0", r); end
  endtask

  task automatic test_custom_div1();
    bus.div_sel = 2; bus.div_custom = 0; bus.enable = 1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) begin
        checks++; if (bus.div_active !== 8'd1) begin failures++; $display("FAIL c1_div_active got=%0d exp=1", bus.div_active); end
      end
      checks++; if (bus.sck !== (k % 2 == 0)) begin failures++; $display("FAIL c1_sck k=%0d got=%b exp=%b", k, bus.sck, (k % 2 == 0)); end
      checks++; if (bus.sck_rise !== (k >= 2 && k % 2 == 0)) begin failures++; $display("FAIL c1_rise k=%0d got=%b", k, bus.sck_rise); end
      checks++; if (bus.sck_fall !== (k >= 3 && k % 2 == 1)) begin failures++; $display("FAIL c1_fall k=%0d got=%b", k, bus.sck_fall); end
    end
    // sck is high here, so dropping enable produces one final fall.
    bus.enable = 0;
    step();
    checks++; if ({bus.sck_fall, bus.running, bus.sck} !== 3'b100) begin failures++; $display("FAIL c1_exit got=%b exp=100", {bus.sck_fall, bus.running, bus.sck}); end
    step();
    bus.burst_len = 0; bus.burst_start = 1;
    step();
    bus.burst_start = 0;
    checks++; if (bus.burst_done !== 1'b1) begin failures++; $display("FAIL zero_burst_done got=%b exp=1", bus.burst_done); end
    checks++; if ({bus.running, bus.sck_rise, bus.sck_fall} !== 3'b000) begin failures++; $display("FAIL zero_burst_edges got=%b exp=000", {bus.running, bus.sck_rise, bus.sck_fall}); end
    step();
    checks++; if ({bus.burst_done, bus.running} !== 2'b00) begin failures++; $display("FAIL zero_burst_single got=%b exp=00", {bus.burst_done, bus.running}); end
  endtask

  task automatic test_reset_mid_burst();
    int n;
    int bad;
    bus.div_sel = 0; bus.burst_len = 8'd74; bus.burst_start = 1;
    step();
    bus.burst_start = 0;
    wait_edge(1, 400, n);
    checks++; if (n !== 125) begin failures++; $display("FAIL mb_rise got=%0d exp=125", n); end
    bus.div_sel = 1;
    for (int i = 0; i < 5; i++) step();
    #2 n_reset = 0;
    #1;
    checks++; if ({bus.sck, bus.running, bus.burst_done} !== 3'b000) begin failures++; $display("FAIL mb_async got=%b exp=000", {bus.sck, bus.running, bus.burst_done}); end
    checks++; if (bus.div_active !== 8'd125) begin failures++; $display("FAIL mb_div got=%0d exp=125", bus.div_active); end
    @(negedge clock);
    n_reset = 1;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.sck || bus.sck_rise || bus.burst_done || bus.running) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL mb_idle_after got=%0d exp=0", bad); end
  endtask

  initial begin
    test_reset();
    test_slow_run();
    test_div_switch();
    test_enable_drop();
    test_burst74();
    test_custom_div1();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
